// File: rtl/fft_stage_sched.sv
// fft_stage_sched: sequences N_STAGES FFT butterfly stages over two ping-pong
// sample banks. One stage runs at a time, strictly in index order. Every stage
// reads the bank that the previous stage wrote.
// Optional build macro FFT_STAGE_SCHED_PERF_EN adds the frame_cycles output.
// frame_cycles is the number of cycles from descriptor accept to first out_valid,
// counting both of those cycles.
module fft_stage_sched #(
    parameter int N_STAGES = 10,
    parameter int IDX_W    = 4
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                in_valid,
    input  logic                in_bank,
    output logic                in_ready,
    output logic [N_STAGES-1:0] stage_start,
    input  logic [N_STAGES-1:0] stage_ready,
    input  logic [N_STAGES-1:0] stage_done,
    output logic [N_STAGES-1:0] stage_continue,
    output logic                rd_bank_sel,
    output logic                wr_bank_sel,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                out_valid,
    output logic                out_bank,
    input  logic                out_ready,
    output logic                busy,
    output logic                err
`ifdef FFT_STAGE_SCHED_PERF_EN
    ,
    output logic [31:0]         frame_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_ACK,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [IDX_W-1:0] idx_d;
    logic            cur_bank_q, bank_d;
    logic [N_STAGES-1:0] sel;
    logic            cur_ready, cur_done, last, accept, err_c;

    // One-hot decode by compare so the index width never has to match the vector.
    function automatic logic [N_STAGES-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_STAGES-1:0] v;
        for (int k = 0; k < N_STAGES; k++) v[k] = (i == IDX_W'(k));
        return v;
    endfunction

    // Handshake terms of the currently selected stage.
    always_comb begin
        sel       = onehot(stage_idx);
        cur_ready = |(stage_ready & sel);
        cur_done  = |(stage_done & sel);
        last      = (stage_idx == IDX_W'(N_STAGES - 1));
        accept    = in_valid && in_ready;
    end

    // Next-state, next stage index and next read bank.
    always_comb begin
        state_d = state_q;
        idx_d   = stage_idx;
        bank_d  = cur_bank_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LAUNCH;
                    idx_d   = '0;
                    bank_d  = in_bank;
                end
            end
            S_LAUNCH: begin
                if (cur_ready) state_d = cur_done ? S_ACK : S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (cur_done) state_d = S_ACK;
            end
            S_ACK: begin
                if (last) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_LAUNCH;
                    idx_d   = stage_idx + 1'b1;
                    bank_d  = ~cur_bank_q;
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Protocol violations. A handshake from a stage that is not selected is an
    // error, and so is any done while no frame is running.
    always_comb begin
        err_c = 1'b0;
        if (state_q == S_IDLE) err_c = |stage_done;
        else                   err_c = |((stage_done | stage_ready) & ~sel);
    end

    // State and registered outputs. The outputs are decoded from the next state,
    // so they line up with the state and have no combinational paths from the inputs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q        <= S_IDLE;
            stage_idx      <= '0;
            cur_bank_q     <= 1'b0;
            in_ready       <= 1'b0;
            stage_start    <= '0;
            stage_continue <= '0;
            rd_bank_sel    <= 1'b0;
            wr_bank_sel    <= 1'b0;
            out_valid      <= 1'b0;
            out_bank       <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state_q        <= state_d;
            stage_idx      <= idx_d;
            cur_bank_q     <= bank_d;
            in_ready       <= (state_d == S_IDLE);
            stage_start    <= (state_d == S_LAUNCH) ? onehot(idx_d) : '0;
            stage_continue <= (state_d == S_ACK) ? onehot(idx_d) : '0;
            // Bank selects move only when a stage is entered, so each stage sees
            // stable selects from its launch through its acknowledge.
            if (state_d == S_LAUNCH && state_q != S_LAUNCH) begin
                rd_bank_sel <= bank_d;
                wr_bank_sel <= ~bank_d;
            end
            out_valid      <= (state_d == S_OUT);
            out_bank       <= (state_d == S_OUT) ? ~bank_d : 1'b0;
            busy           <= (state_d != S_IDLE);
            err            <= err | err_c;
        end
    end

`ifdef FFT_STAGE_SCHED_PERF_EN
    // Frame length counter. It is seeded with 2 to count the accept cycle and the
    // first out_valid cycle. It counts stage-running cycles and is frozen while in OUT.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            frame_cycles <= '0;
        end else if (accept) begin
            frame_cycles <= 32'd2;
        end else if (state_q == S_LAUNCH || state_q == S_WAIT_DONE || state_q == S_ACK) begin
            if (frame_cycles != 32'hFFFF_FFFF) frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif

endmodule
